// File: rtl/gshare_bht.sv
// gshare_bht: 2^N saturating-counter predictor, zero-cycle prediction, no backpressure (stall only freezes GHR).
// BHT_GSHARE_EN selects gshare hashing with a speculative GHR; undefined builds a bimodal table with o_ghr tied to 0.
module gshare_bht #(
   parameter int SET_COUNT     = 64,
   parameter int INDEX_WIDTH   = 6,
   parameter int SATUR_COUNT_W = 2,
   parameter int GHR_WIDTH     = 6
) (
   input  logic                     i_clk,
   input  logic                     i_arst,
   input  logic                     i_stall_fetch,
   input  logic                     i_fetch_branch,
   input  logic [INDEX_WIDTH-1:0]   i_set_index,
   input  logic                     i_bht_update,
   input  logic                     i_branch_taken,
   input  logic                     i_mispredict,
   input  logic [INDEX_WIDTH-1:0]   i_set_index_exec,
   input  logic [GHR_WIDTH-1:0]     i_ghr_exec,
   output logic                     o_bht_pred_taken,
   output logic [GHR_WIDTH-1:0]     o_ghr
);

   localparam logic [SATUR_COUNT_W-1:0] WEAK_NT = SATUR_COUNT_W'((1 << (SATUR_COUNT_W - 1)) - 1);
   localparam logic [SATUR_COUNT_W-1:0] CNT_MAX = {SATUR_COUNT_W{1'b1}};

   logic [SATUR_COUNT_W-1:0] table_q [SET_COUNT];
   logic [INDEX_WIDTH-1:0]   rd_idx;
   logic [INDEX_WIDTH-1:0]   wr_idx;
   logic [SATUR_COUNT_W-1:0] cnt_cur;
   logic [SATUR_COUNT_W-1:0] cnt_next;

`ifdef BHT_GSHARE_EN
   logic [GHR_WIDTH-1:0] ghr_q;

   assign rd_idx = i_set_index ^ INDEX_WIDTH'(ghr_q);
   assign wr_idx = i_set_index_exec ^ INDEX_WIDTH'(i_ghr_exec);
   assign o_ghr  = ghr_q;

   // Shift-in via truncating cast keeps GHR_WIDTH = 1 legal without a special case.
   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         ghr_q <= '0;
      end else if (i_bht_update && i_mispredict) begin
         ghr_q <= GHR_WIDTH'({i_ghr_exec, i_branch_taken});
      end else if (i_fetch_branch && !i_stall_fetch) begin
         ghr_q <= GHR_WIDTH'({ghr_q, o_bht_pred_taken});
      end
   end
`else
   logic unused_inputs;

   assign rd_idx        = i_set_index;
   assign wr_idx        = i_set_index_exec;
   assign o_ghr         = '0;
   assign unused_inputs = ^{i_stall_fetch, i_fetch_branch, i_mispredict, i_ghr_exec};
`endif

   assign o_bht_pred_taken = table_q[rd_idx][SATUR_COUNT_W-1];
   assign cnt_cur          = table_q[wr_idx];

   always_comb begin
      cnt_next = cnt_cur;
      if (i_branch_taken) begin
         if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 1'b1;
      end else begin
         if (cnt_cur != '0) cnt_next = cnt_cur - 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         for (int i = 0; i < SET_COUNT; i++) table_q[i] <= WEAK_NT;
      end else if (i_bht_update) begin
         table_q[wr_idx] <= cnt_next;
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// Bench for gshare_bht: 2-bit and 3-bit counter instances driven in parallel against a scoreboard model.
module tb_gshare_bht;

   localparam int IW = 6;
   localparam int GW = 6;
   localparam int SC = 64;
`ifdef BHT_GSHARE_EN
   localparam bit GS = 1'b1;
`else
   localparam bit GS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          stall = 1'b0;
   logic          fetch_branch = 1'b0;
   logic [IW-1:0] set_index = '0;
   logic          bht_update = 1'b0;
   logic          branch_taken = 1'b0;
   logic          mispredict = 1'b0;
   logic [IW-1:0] set_index_exec = '0;
   logic [GW-1:0] ghr_exec = '0;
   logic          pred2, pred3;
   logic [GW-1:0] ghr2, ghr3;

   always #5 clk = ~clk;

   gshare_bht #(.SET_COUNT(SC), .INDEX_WIDTH(IW), .SATUR_COUNT_W(2), .GHR_WIDTH(GW)) u_w2 (
      .i_clk(clk), .i_arst(arst), .i_stall_fetch(stall), .i_fetch_branch(fetch_branch),
      .i_set_index(set_index), .i_bht_update(bht_update), .i_branch_taken(branch_taken),
      .i_mispredict(mispredict), .i_set_index_exec(set_index_exec), .i_ghr_exec(ghr_exec),
      .o_bht_pred_taken(pred2), .o_ghr(ghr2)
   );

   gshare_bht #(.SET_COUNT(SC), .INDEX_WIDTH(IW), .SATUR_COUNT_W(3), .GHR_WIDTH(GW)) u_w3 (
      .i_clk(clk), .i_arst(arst), .i_stall_fetch(stall), .i_fetch_branch(fetch_branch),
      .i_set_index(set_index), .i_bht_update(bht_update), .i_branch_taken(branch_taken),
      .i_mispredict(mispredict), .i_set_index_exec(set_index_exec), .i_ghr_exec(ghr_exec),
      .o_bht_pred_taken(pred3), .o_ghr(ghr3)
   );

   typedef struct packed {
      logic          p0;
      logic [GW-1:0] g0;
      logic          p1;
      logic [GW-1:0] g1;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    mt[2][SC];
   int    ghr_m[2];
   int    cmax[2] = '{3, 7};
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic bit mpred(input int k, input int idx);
      int rd;
      rd = (idx ^ (GS ? ghr_m[k] : 0)) & (SC - 1);
      return mt[k][rd] > cmax[k] / 2;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < SC; i++) mt[k][i] = cmax[k] / 2;
         ghr_m[k] = 0;
      end
   endfunction

   task automatic cycle(input string tag, input bit f, input bit st, input int si, input bit u,
                        input bit t, input bit m, input int se, input int ge);
      exp_t  e;
      string tg;
      bit    pk[2];
      int    wr;
      @(negedge clk);
      fetch_branch   = f;
      stall          = st;
      set_index      = IW'(si);
      bht_update     = u;
      branch_taken   = t;
      mispredict     = m;
      set_index_exec = IW'(se);
      ghr_exec       = GW'(ge);
      pk[0] = mpred(0, si);
      pk[1] = mpred(1, si);
      exp_q.push_back('{pk[0], GW'(ghr_m[0]), pk[1], GW'(ghr_m[1])});
      tag_q.push_back(tag);
      #1;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      check({tg, "_pred_w2"}, int'(pred2), int'(e.p0));
      check({tg, "_ghr_w2"},  int'(ghr2),  int'(e.g0));
      check({tg, "_pred_w3"}, int'(pred3), int'(e.p1));
      check({tg, "_ghr_w3"},  int'(ghr3),  int'(e.g1));
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (u) begin
            wr = (se ^ (GS ? ge : 0)) & (SC - 1);
            if (t && mt[k][wr] < cmax[k]) mt[k][wr]++;
            else if (!t && mt[k][wr] > 0) mt[k][wr]--;
         end
         if (GS) begin
            if (u && m) ghr_m[k] = ((ge << 1) | int'(t)) & (SC - 1);
            else if (f && !st) ghr_m[k] = ((ghr_m[k] << 1) | int'(pk[k])) & (SC - 1);
         end
      end
   endtask

   task automatic idle_inputs();
      fetch_branch = 1'b0; stall = 1'b0; bht_update = 1'b0;
      branch_taken = 1'b0; mispredict = 1'b0; ghr_exec = '0;
   endtask

   task automatic check_reset_held(input string tag);
      check({tag, "_pred_w2"}, int'(pred2), 0);
      check({tag, "_ghr_w2"},  int'(ghr2),  0);
      check({tag, "_pred_w3"}, int'(pred3), 0);
      check({tag, "_ghr_w3"},  int'(ghr3),  0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      arst = 1'b1;
      model_reset();
      #1 check_reset_held("rst_held");
      @(negedge clk);
      arst = 1'b0;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < SC; i++) cycle(tag, 0, 0, i, 0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      #2 check_reset_held("por");
      @(negedge clk);
      arst = 1'b0;
      sweep("rst_sweep");

      // Saturation up then down, then one step up to expose any wrap.
      for (int i = 0; i < 5; i++) cycle("sat_up", 0, 0, 5, 1, 1, 0, 5, 0);
      cycle("sat_up_rd", 0, 0, 5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle("sat_dn", 0, 0, 5, 1, 0, 0, 5, 0);
      cycle("sat_dn_rd", 0, 0, 5, 1, 1, 0, 5, 0);
      cycle("sat_wrap_rd", 0, 0, 5, 0, 0, 0, 0, 0);

      // Speculative history over a fully taken table.
      do_reset();
      for (int i = 0; i < SC; i++) begin
         cycle("train_all", 0, 0, i, 1, 1, 0, i, 0);
         cycle("train_all", 0, 0, i, 1, 1, 0, i, 0);
      end
      for (int i = 0; i < 3; i++) cycle("spec_shift", 1, 0, 0, 0, 0, 0, 0, 0);
      cycle("spec_shift_rd", 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("ghr_clear", 0, 0, 0, 1, 0, 1, 40, 0);
      cycle("stall_b1", 1, 0, 0, 0, 0, 0, 0, 0);
      cycle("stall_b2", 1, 1, 0, 0, 0, 0, 0, 0);
      cycle("stall_b2b", 1, 1, 0, 0, 0, 0, 0, 0);
      cycle("stall_train", 1, 1, 0, 1, 1, 0, 12, 0);
      cycle("stall_b3", 1, 0, 0, 0, 0, 0, 0, 0);
      cycle("stall_rd", 0, 0, 0, 0, 0, 0, 0, 0);

      // Recovery beats the speculative shift.
      cycle("ghr_set", 0, 0, 0, 1, 0, 1, 41, 6'b010101);
      cycle("recov_prio", 1, 0, 0, 1, 1, 1, 42, 6'b000100);
      cycle("recov_rd", 0, 0, 0, 0, 0, 0, 0, 0);
      cycle("mis_no_upd", 0, 0, 0, 0, 1, 1, 43, 6'b111111);
      cycle("mis_no_upd_rd", 0, 0, 0, 0, 0, 0, 0, 0);

      // Hash aliasing and same-cycle read/write.
      do_reset();
      cycle("alias_tr", 0, 0, 2, 1, 1, 0, 3, 1);
      cycle("alias_tr", 0, 0, 2, 1, 1, 0, 3, 1);
      cycle("alias_g1", 0, 0, 2, 1, 1, 1, 40, 0);
      cycle("alias_rd2", 0, 0, 2, 0, 0, 0, 0, 0);
      cycle("alias_g0", 0, 0, 3, 1, 0, 1, 40, 0);
      cycle("alias_rd3", 0, 0, 3, 0, 0, 0, 0, 0);
      cycle("rw_same", 0, 0, 7, 1, 1, 0, 7, 0);
      cycle("rw_same", 0, 0, 7, 1, 1, 0, 7, 0);
      cycle("rw_after", 0, 0, 7, 0, 0, 0, 0, 0);

      // Reset asserted in the middle of an update cycle.
      @(negedge clk);
      set_index = IW'(9); set_index_exec = IW'(9);
      bht_update = 1'b1; branch_taken = 1'b1; mispredict = 1'b1; ghr_exec = GW'(6'b110011);
      #2 arst = 1'b1;
      model_reset();
      #1 check_reset_held("mid_rst");
      @(posedge clk);
      #1 check_reset_held("mid_rst_edge");
      @(negedge clk);
      idle_inputs();
      arst = 1'b0;
      sweep("mid_rst_sweep");

      for (int i = 0; i < 400; i++) begin
         cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, SC - 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, SC - 1)), int'($urandom_range(0, SC - 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
